// File: rtl/mem_arbiter_ctrl.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Optional MEM_ARB_IO_STALL_EN: store beats into the IO window are held while the UART buffer is full.
module mem_arbiter_ctrl #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        if_signal,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_signal,
    input  logic        lsb_wr,
    input  logic        lsb_signed,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_dout,
    output logic [31:0] lsb_din,
    output logic        lsb_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_e;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [2:0]           nbytes_q, nbytes_d;
    logic [2:0]           beat_q, beat_d;
    logic                 own_if_q, own_if_d;
    logic                 sgn_q, sgn_d;
    logic [CNT_WIDTH-1:0] starve_q, starve_d;

    logic        if_req, ls_req, grant_if, grant_ls;
    logic        last_wr_beat;
    logic        io_stall;
    logic [31:0] beat_addr;

    // A flush masks fetches and loads in IDLE; stores are never speculative.
    assign if_req   = if_signal & ~clear_signal;
    assign ls_req   = lsb_signal & (lsb_wr | ~clear_signal);
    assign grant_if = if_req & (~ls_req | (starve_q == LIMIT));
    assign grant_ls = ls_req & ~grant_if;

    assign beat_addr    = addr_q + {29'b0, beat_q};
    assign last_wr_beat = (beat_q == nbytes_q - 3'd1);

`ifdef MEM_ARB_IO_STALL_EN
    assign io_stall = (state_q == LS_WR) && io_buffer_full && (beat_addr[17:16] == 2'b11);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            nbytes_q <= '0;
            beat_q   <= '0;
            own_if_q <= 1'b0;
            sgn_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            nbytes_q <= nbytes_d;
            beat_q   <= beat_d;
            own_if_q <= own_if_d;
            sgn_q    <= sgn_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        nbytes_d = nbytes_q;
        beat_d   = beat_q;
        own_if_d = own_if_q;
        sgn_d    = sgn_q;
        starve_d = starve_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        state_d  = IF_RD;
                        addr_d   = if_addr;
                        data_d   = '0;
                        nbytes_d = 3'd4;
                        beat_d   = '0;
                        own_if_d = 1'b1;
                        sgn_d    = 1'b0;
                        starve_d = '0;
                    end else if (grant_ls) begin
                        state_d  = lsb_wr ? LS_WR : LS_RD;
                        addr_d   = lsb_addr;
                        data_d   = lsb_wr ? lsb_dout : 32'b0;
                        beat_d   = '0;
                        own_if_d = 1'b0;
                        sgn_d    = lsb_signed;
                        case (lsb_len)
                            2'b00:   nbytes_d = 3'd1;
                            2'b01:   nbytes_d = 3'd2;
                            default: nbytes_d = 3'd4;
                        endcase
                        if (if_signal && starve_q != LIMIT)
                            starve_d = starve_q + 1'b1;
                    end
                end
                IF_RD, LS_RD: begin
                    if (clear_signal) begin
                        state_d = IDLE;
                    end else begin
                        // Byte k-1 arrives while beat k is being addressed.
                        for (int i = 0; i < 4; i++)
                            if (beat_q == 3'(i + 1))
                                data_d[8*i +: 8] = mem_din;
                        if (beat_q == nbytes_q)
                            state_d = DONE;
                        else
                            beat_d = beat_q + 3'd1;
                    end
                end
                LS_WR: begin
                    if (!io_stall) begin
                        if (last_wr_beat)
                            state_d = DONE;
                        else
                            beat_d = beat_q + 3'd1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if_done  = 1'b0;
        lsb_done = 1'b0;
        case (state_q)
            IF_RD, LS_RD: mem_a = beat_addr;
            LS_WR: begin
                mem_a    = beat_addr;
                mem_dout = data_q[{beat_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in & ~io_stall;
            end
            DONE: begin
                if_done  = own_if_q;
                lsb_done = ~own_if_q;
            end
            default: ;
        endcase
    end

    assign if_data = data_q;

    always_comb begin
        case (nbytes_q)
            3'd1:    lsb_din = {{24{sgn_q & data_q[7]}}, data_q[7:0]};
            3'd2:    lsb_din = {{16{sgn_q & data_q[15]}}, data_q[15:0]};
            default: lsb_din = data_q;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed cases plus a randomized queue-driven run
// checked against a transaction-level memory/arbitration model.
module tb_mem_arbiter_ctrl;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy_in = 1'b1, clear_signal = 1'b0;
    logic        if_signal = 1'b0, lsb_signal = 1'b0, lsb_wr = 1'b0, lsb_signed = 1'b0;
    logic [31:0] if_addr = '0, lsb_addr = '0, lsb_dout = '0;
    logic [1:0]  lsb_len = '0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic        if_done, lsb_done, mem_wr;
    logic [31:0] if_data, lsb_din, mem_a;
    logic [7:0]  mem_dout;

    mem_arbiter_ctrl #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .if_signal(if_signal), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_dout(lsb_dout), .lsb_din(lsb_din), .lsb_done(lsb_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM pauses with the rest of the system; read data appears one cycle after the address.
    logic [7:0] ram [0:4095];
    logic [7:0] ref_mem [0:4095];
    always @(posedge clk) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    typedef struct { bit wr; bit sg; logic [1:0] len; logic [31:0] a; logic [31:0] d; } lreq_t;

    int n_chk = 0, n_err = 0, m_starve = 0, full_until = -1;
    logic        s_ifd, s_lsd, s_wr;
    logic [31:0] s_ifdata, s_lsdin, s_mema;
    logic [31:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [31:0] a_log [0:15];
    lreq_t       lq[$];
    logic [31:0] iq[$];
    bit          own_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the falling edge on which inputs were driven.
    task automatic step();
        #1;
        s_ifd = if_done & rdy_in;
        s_lsd = lsb_done & rdy_in;
        s_ifdata = if_data; s_lsdin = lsb_din; s_mema = mem_a; s_wr = mem_wr;
        if (rdy_in && mem_wr) begin
            wq_a.push_back(mem_a);
            wq_d.push_back(mem_dout);
        end
        if (!rdy_in) chk("pause_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
    endtask

    function automatic int nb(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] len, input bit sg);
        logic [31:0] v = '0, ak;
        int n = nb(len);
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v = v | ({24'b0, ref_mem[ak[11:0]]} << (8 * k));
        end
        if (sg && n == 1) v = 32'($signed(v[7:0]));
        if (sg && n == 2) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    function automatic bit predict(input bit if_p, input bit ls_p);
        if (ls_p && !(if_p && m_starve == STARVE_LIMIT)) begin
            if (if_p && m_starve < STARVE_LIMIT) m_starve++;
            return 1'b0;
        end
        m_starve = 0;
        return 1'b1;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a[11:0]] = b;
        ref_mem[a[11:0]] = b;
    endtask

    task automatic chk_beats(input string tag, input logic [31:0] a, input logic [31:0] d, input int n);
        chk({tag, "_nbeats"}, 32'(wq_a.size()), 32'(n));
        for (int k = 0; k < n && k < wq_a.size(); k++) begin
            chk({tag, "_addr"}, wq_a[k], a + 32'(k));
            chk({tag, "_byte"}, {24'b0, wq_d[k]}, {24'b0, d[8*k +: 8]});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_signal = 0; lsb_signal = 0; clear_signal = 0; rdy_in = 1; io_buffer_full = 0;
        step(); step();
        chk("rst_mem_a", s_mema, 0);
        chk("rst_mem_wr", 32'(s_wr), 0);
        chk("rst_done", {30'b0, if_done, lsb_done}, 0);
        chk("rst_if_data", s_ifdata, 0);
        chk("rst_lsb_din", s_lsdin, 0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 0);
        rst_n = 1'b1;
        m_starve = 0;
    endtask

    // One isolated request raised at step 0; lat is the step index of the done pulse.
    task automatic txn(input bit is_if, input bit wr, input bit sg, input logic [1:0] len,
                       input logic [31:0] a, input logic [31:0] d, input int clr_at, input bit drop,
                       output bit seen, output int lat, output logic [31:0] data);
        int c = 0;
        seen = 0; lat = -1; data = '0;
        wq_a.delete(); wq_d.delete();
        if (is_if) begin
            if_signal = 1; if_addr = a;
        end else begin
            lsb_signal = 1; lsb_wr = wr; lsb_signed = sg; lsb_len = len; lsb_addr = a; lsb_dout = d;
        end
        while (!seen && c < 16) begin
            clear_signal = (c == clr_at);
            io_buffer_full = (c <= full_until);
            step();
            a_log[c] = s_mema;
            if (clear_signal && drop) begin if_signal = 0; lsb_signal = 0; end
            if (is_if ? s_ifd : s_lsd) begin
                seen = 1; lat = c; data = is_if ? s_ifdata : s_lsdin;
            end
            c++;
        end
        clear_signal = 0; io_buffer_full = 0; if_signal = 0; lsb_signal = 0; full_until = -1;
    endtask

    task automatic run_queues(input bit rnd_rdy);
        lreq_t       cur_l;
        logic [31:0] cur_i = '0;
        bit          l_act = 0, i_act = 0, exp_if;
        int          guard = 0;
        own_log.delete(); wq_a.delete(); wq_d.delete();
        exp_if = predict(iq.size() > 0, lq.size() > 0);
        while ((lq.size() > 0 || iq.size() > 0 || l_act || i_act) && guard < 20000) begin
            if (!l_act && lq.size() > 0) begin
                cur_l = lq.pop_front(); l_act = 1;
                lsb_wr = cur_l.wr; lsb_signed = cur_l.sg; lsb_len = cur_l.len;
                lsb_addr = cur_l.a; lsb_dout = cur_l.d; lsb_signal = 1;
            end
            if (!i_act && iq.size() > 0) begin
                cur_i = iq.pop_front(); i_act = 1; if_addr = cur_i; if_signal = 1;
            end
            rdy_in = rnd_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
            step();
            guard++;
            if (s_ifd || s_lsd) begin
                chk("single_done", 32'(s_ifd & s_lsd), 0);
                chk("owner", 32'(s_ifd), 32'(exp_if));
                own_log.push_back(s_ifd);
                if (s_ifd) begin
                    chk("if_data", s_ifdata, model_load(cur_i, 2'b11, 1'b0));
                    chk("if_no_write", 32'(wq_a.size()), 0);
                    i_act = 0; if_signal = 0;
                end else begin
                    if (cur_l.wr) begin
                        chk_beats("rnd_st", cur_l.a, cur_l.d, nb(cur_l.len));
                        for (int k = 0; k < nb(cur_l.len); k++) begin
                            logic [31:0] ak = cur_l.a + 32'(k);
                            ref_mem[ak[11:0]] = cur_l.d[8*k +: 8];
                        end
                    end else begin
                        chk("rnd_ld", s_lsdin, model_load(cur_l.a, cur_l.len, cur_l.sg));
                    end
                    l_act = 0; lsb_signal = 0;
                end
                wq_a.delete(); wq_d.delete();
                if (l_act || i_act || lq.size() > 0 || iq.size() > 0)
                    exp_if = predict(i_act || iq.size() > 0, l_act || lq.size() > 0);
            end
        end
        if (guard >= 20000) chk("queue_timeout", 32'(guard), 0);
        rdy_in = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          seen;
        int          lat;
        logic [31:0] got;
        logic [4:0]  seq;
        @(negedge clk);
        do_reset();

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        txn(0, 0, 0, 2'b11, 32'h100, 0, -1, 0, seen, lat, got);
        chk("ldw_seen", 32'(seen), 1); chk("ldw_lat", 32'(lat), 6); chk("ldw_data", got, 32'h44332211);

        poke(32'h80, 8'h80); poke(32'h81, 8'h00); poke(32'h82, 8'h00); poke(32'h83, 8'h00);
        txn(0, 0, 1, 2'b00, 32'h80, 0, -1, 0, seen, lat, got);
        chk("ldbs_lat", 32'(lat), 3); chk("ldbs_data", got, 32'hFFFFFF80);

        poke(32'h90, 8'h01); poke(32'h91, 8'h80);
        txn(0, 0, 0, 2'b01, 32'h90, 0, -1, 0, seen, lat, got);
        chk("ldhu_lat", 32'(lat), 4); chk("ldhu_data", got, 32'h00008001);
        txn(0, 0, 1, 2'b01, 32'h90, 0, -1, 0, seen, lat, got);
        chk("ldhs_data", got, 32'hFFFF8001);
        txn(0, 0, 1, 2'b10, 32'h100, 0, -1, 0, seen, lat, got);
        chk("ld10_lat", 32'(lat), 6); chk("ld10_data", got, 32'h44332211);

        txn(0, 1, 0, 2'b11, 32'h200, 32'hDEADBEEF, -1, 0, seen, lat, got);
        chk("stw_lat", 32'(lat), 5); chk_beats("stw", 32'h200, 32'hDEADBEEF, 4);
        txn(0, 0, 0, 2'b11, 32'h200, 0, -1, 0, seen, lat, got);
        chk("stw_readback", got, 32'hDEADBEEF);

        txn(1, 0, 0, 2'b11, 32'h80, 0, -1, 0, seen, lat, got);
        chk("if_lat", 32'(lat), 6); chk("if_noext", got, 32'h00000080);

        poke(32'hFFE, 8'hA1); poke(32'hFFF, 8'hB2); poke(32'h000, 8'hC3); poke(32'h001, 8'hD4);
        txn(0, 0, 0, 2'b11, 32'hFFFFFFFE, 0, -1, 0, seen, lat, got);
        chk("wrap_ld", got, 32'hD4C3B2A1);
        txn(0, 1, 0, 2'b01, 32'hFFFFFFFF, 32'h00007E5A, -1, 0, seen, lat, got);
        chk_beats("wrap_st", 32'hFFFFFFFF, 32'h00007E5A, 2);

        poke(32'h40, 8'h01); poke(32'h41, 8'h02); poke(32'h42, 8'h03); poke(32'h43, 8'h04);
        txn(1, 0, 0, 2'b11, 32'h40, 0, 3, 1, seen, lat, got);
        chk("ifclr_no_done", 32'(seen), 0);
        chk("ifclr_beat2_a", a_log[3], 32'h42);
        chk("ifclr_idle_a", a_log[4], 32'h0);

        txn(0, 0, 0, 2'b00, 32'h40, 0, 2, 1, seen, lat, got);
        chk("ldclr_last_no_done", 32'(seen), 0);
        chk("ldclr_last_idle_a", a_log[3], 32'h0);

        txn(0, 1, 0, 2'b11, 32'h240, 32'hCAFEF00D, 2, 0, seen, lat, got);
        chk("stclr_seen", 32'(seen), 1); chk("stclr_lat", 32'(lat), 5);
        chk_beats("stclr", 32'h240, 32'hCAFEF00D, 4);

        txn(0, 0, 0, 2'b00, 32'h40, 0, 0, 0, seen, lat, got);
        chk("idleclr_ld_lat", 32'(lat), 4); chk("idleclr_ld_data", got, 32'h01);
        txn(0, 1, 0, 2'b00, 32'h250, 32'h77, 0, 0, seen, lat, got);
        chk("idleclr_st_lat", 32'(lat), 2);

        full_until = 5;
        txn(0, 1, 0, 2'b00, 32'h00030000, 32'h5A, -1, 0, seen, lat, got);
`ifdef MEM_ARB_IO_STALL_EN
        chk("io_stall_lat", 32'(lat), 7);
`else
        chk("io_nostall_lat", 32'(lat), 2);
`endif
        chk_beats("io_st", 32'h00030000, 32'h5A, 1);

        lsb_signal = 1; lsb_wr = 1; lsb_len = 2'b11; lsb_addr = 32'h300; lsb_dout = 32'h12345678;
        step(); step(); step();
        rst_n = 1'b0; lsb_signal = 0;
        #1;
        chk("rst_mid_wr", 32'(mem_wr), 0);
        chk("rst_mid_a", mem_a, 0);
        @(negedge clk);
        rst_n = 1'b1; m_starve = 0;
        txn(0, 0, 0, 2'b11, 32'h100, 0, -1, 0, seen, lat, got);
        chk("post_rst_lat", 32'(lat), 6); chk("post_rst_data", got, 32'h44332211);

        do_reset();
        for (int i = 0; i < 6; i++) lq.push_back('{0, 0, 2'b11, 32'h100 + 32'(4 * i), 0});
        for (int i = 0; i < 2; i++) iq.push_back(32'h400 + 32'(4 * i));
        run_queues(0);
        seq = '0;
        for (int i = 0; i < 5 && i < own_log.size(); i++) seq = {seq[3:0], own_log[i]};
        chk("starve_seq", {27'b0, seq}, 32'b00001);

        do_reset();
        for (int i = 0; i < 4096; i++) begin
            logic [7:0] b = 8'($urandom);
            ram[i] = b; ref_mem[i] = b;
        end
        for (int i = 0; i < 30; i++) begin
            lreq_t r;
            r.wr = 1'($urandom); r.sg = 1'($urandom); r.len = 2'($urandom);
            r.a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                              : 32'($urandom_range(0, 255));
            r.d = $urandom;
            lq.push_back(r);
        end
        for (int i = 0; i < 12; i++) iq.push_back(32'($urandom_range(0, 300)));
        run_queues(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
